// File: rtl/sequence_loader.sv
// Loads COUNT Simon colours into the sequence RAM, sourced from the level ROM or a 16-bit LFSR.
// One write strobe per entry, with busy/done handshake, abort and an entries-written count.
module sequence_loader #(
    parameter int COLOR_W = 2,
    parameter int DEPTH   = 8,
    parameter int ROM_LAT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       go,
    input  logic                       mode,
    input  logic [$clog2(DEPTH):0]     count,
    input  logic [15:0]                seed,
    input  logic                       abort,
    output logic [$clog2(DEPTH)-1:0]   rom_addr,
    output logic                       rom_rd,
    input  logic [COLOR_W-1:0]         rom_data,
    output logic [$clog2(DEPTH)-1:0]   wr_addr,
    output logic [COLOR_W-1:0]         wr_data,
    output logic                       write,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     loaded
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_CNT   = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_IDX   = AW'(1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(ROM_LAT - 1);
    localparam logic [WW-1:0] ONE_WAIT  = WW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_GEN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t               state_reg, state_next;
    logic                 mode_reg, mode_next;
    logic [AW:0]          count_reg, count_next;
    logic [15:0]          lfsr_reg, lfsr_next;
    logic [AW-1:0]        idx_reg, idx_next;
    logic [WW-1:0]        wait_reg, wait_next;
    logic [AW-1:0]        rom_addr_reg, rom_addr_next;
    logic                 rom_rd_reg, rom_rd_next;
    logic [AW-1:0]        wr_addr_reg, wr_addr_next;
    logic [COLOR_W-1:0]   wr_data_reg, wr_data_next;
    logic                 write_reg, write_next;
    logic                 done_reg, done_next;
    logic [AW:0]          loaded_reg, loaded_next;

    logic [AW:0]          count_eff;
    logic [15:0]          seed_eff;
    logic [15:0]          lfsr_step;
    logic                 last_entry;

    // Zero or oversize requests load the whole memory; an all-zero seed would lock the LFSR.
    assign count_eff  = (count == '0 || count > DEPTH_CNT) ? DEPTH_CNT : count;
    assign seed_eff   = (seed == 16'h0000) ? 16'h0001 : seed;
    assign lfsr_step  = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    assign last_entry = ({1'b0, idx_reg} == (count_reg - ONE_CNT));

    always_comb begin
        state_next    = state_reg;
        mode_next     = mode_reg;
        count_next    = count_reg;
        lfsr_next     = lfsr_reg;
        idx_next      = idx_reg;
        wait_next     = wait_reg;
        rom_addr_next = '0;
        rom_rd_next   = 1'b0;
        wr_addr_next  = wr_addr_reg;
        wr_data_next  = wr_data_reg;
        write_next    = 1'b0;
        done_next     = 1'b0;
        loaded_next   = loaded_reg;

        case (state_reg)
            S_IDLE: begin
                if (go) begin
                    mode_next   = mode;
                    count_next  = count_eff;
                    lfsr_next   = seed_eff;
                    idx_next    = '0;
                    loaded_next = '0;
                    if (mode) begin
                        state_next = S_GEN;
                    end else begin
                        state_next    = S_FETCH;
                        rom_rd_next   = 1'b1;
                        rom_addr_next = '0;
                    end
                end
            end
            S_FETCH: begin
                state_next = S_WAIT;
                wait_next  = '0;
            end
            S_WAIT: begin
                if (wait_reg == WAIT_LAST) begin
                    wr_data_next = rom_data;
                    wr_addr_next = idx_reg;
                    write_next   = 1'b1;
                    state_next   = S_WRITE;
                end else begin
                    wait_next = wait_reg + ONE_WAIT;
                end
            end
            S_GEN: begin
                wr_data_next = lfsr_reg[COLOR_W-1:0];
                wr_addr_next = idx_reg;
                write_next   = 1'b1;
                lfsr_next    = lfsr_step;
                state_next   = S_WRITE;
            end
            S_WRITE: begin
                loaded_next = loaded_reg + ONE_CNT;
                if (last_entry) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                end else begin
                    idx_next = idx_reg + ONE_IDX;
                    if (mode_reg) begin
                        state_next = S_GEN;
                    end else begin
                        state_next    = S_FETCH;
                        rom_rd_next   = 1'b1;
                        rom_addr_next = idx_reg + ONE_IDX;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Abort cancels pending work; a write strobe already on the bus still counts above.
        if (abort && state_reg != S_IDLE) begin
            state_next    = S_IDLE;
            idx_next      = idx_reg;
            lfsr_next     = lfsr_reg;
            wr_addr_next  = wr_addr_reg;
            wr_data_next  = wr_data_reg;
            rom_addr_next = '0;
            rom_rd_next   = 1'b0;
            write_next    = 1'b0;
            done_next     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            mode_reg     <= 1'b0;
            count_reg    <= '0;
            lfsr_reg     <= '0;
            idx_reg      <= '0;
            wait_reg     <= '0;
            rom_addr_reg <= '0;
            rom_rd_reg   <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            write_reg    <= 1'b0;
            done_reg     <= 1'b0;
            loaded_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            mode_reg     <= mode_next;
            count_reg    <= count_next;
            lfsr_reg     <= lfsr_next;
            idx_reg      <= idx_next;
            wait_reg     <= wait_next;
            rom_addr_reg <= rom_addr_next;
            rom_rd_reg   <= rom_rd_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
            write_reg    <= write_next;
            done_reg     <= done_next;
            loaded_reg   <= loaded_next;
        end
    end

    assign rom_addr = rom_addr_reg;
    assign rom_rd   = rom_rd_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;
    assign write    = write_reg;
    assign done     = done_reg;
    assign loaded   = loaded_reg;
    assign busy     = (state_reg != S_IDLE);

endmodule

// File: tb/tb_sequence_loader.sv
// Bench for sequence_loader: two instances (ROM latency 1 and 3) sharing stimulus,
// a table of load requests, and a write scoreboard filled when each load is requested.
module tb_sequence_loader;

    localparam int COLOR_W = 2;
    localparam int DEPTH   = 8;
    localparam int AW      = 3;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    typedef struct {
        int          sel;
        bit          mode;
        int          count;
        logic [15:0] seed;
        logic [15:0] eff_seed;
        int          abort_after;
        int          exp_writes;
        int          exp_loaded;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               go_s [2];
    logic               mode_s;
    logic [AW:0]        count_s;
    logic [15:0]        seed_s;
    logic               abort_s;

    logic [AW-1:0]      dut_rom_addr [2];
    logic               dut_rom_rd   [2];
    logic [COLOR_W-1:0] dut_rom_data [2];
    logic [AW-1:0]      dut_wr_addr  [2];
    logic [COLOR_W-1:0] dut_wr_data  [2];
    logic               dut_write    [2];
    logic               dut_busy     [2];
    logic               dut_done     [2];
    logic [AW:0]        dut_loaded   [2];

    logic [COLOR_W-1:0] rom_mem [DEPTH];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Instance 0 has a one-cycle ROM, instance 1 a three-cycle ROM; data read at the wrong time is inverted.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 1 : 3;
        logic [COLOR_W:0] pipe [LAT];

        always @(posedge clk) begin
            pipe[0] <= {dut_rom_rd[gi], rom_mem[dut_rom_addr[gi]]};
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end

        assign dut_rom_data[gi] = pipe[LAT-1][COLOR_W] ? pipe[LAT-1][COLOR_W-1:0]
                                                       : ~pipe[LAT-1][COLOR_W-1:0];

        sequence_loader #(.COLOR_W(COLOR_W), .DEPTH(DEPTH), .ROM_LAT(LAT)) dut (
            .clk      (clk),
            .reset    (reset),
            .go       (go_s[gi]),
            .mode     (mode_s),
            .count    (count_s),
            .seed     (seed_s),
            .abort    (abort_s),
            .rom_addr (dut_rom_addr[gi]),
            .rom_rd   (dut_rom_rd[gi]),
            .rom_data (dut_rom_data[gi]),
            .wr_addr  (dut_wr_addr[gi]),
            .wr_data  (dut_wr_data[gi]),
            .write    (dut_write[gi]),
            .busy     (dut_busy[gi]),
            .done     (dut_done[gi]),
            .loaded   (dut_loaded[gi])
        );
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Scoreboard state: written by the test, consumed by the monitor.
    exp_t exp_q [$];
    int   cyc = 0;
    int   sel = 0;
    bit   cur_mode = 1'b0;
    int   period = 3;
    int   load_id = 0;
    int   mon_load_id = 0;
    int   wr_seen = 0;
    int   rd_seen = 0;
    int   done_seen = 0;
    int   last_wr_cyc = 0;
    int   last_rd_cyc = 0;
    int   done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (dut_write[i]) begin
                if (i != sel || exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", int'(dut_wr_addr[i]), e.addr);
                    check("wr_data", int'(dut_wr_data[i]), e.data);
                    if (mon_load_id == load_id) check("write_spacing", cyc - last_wr_cyc, period);
                    if (!cur_mode) check("rd_to_write", cyc - last_rd_cyc, (i == 0) ? 2 : 4);
                    mon_load_id <= load_id;
                    last_wr_cyc <= cyc;
                    wr_seen     <= wr_seen + 1;
                end
            end
            if (dut_rom_rd[i]) begin
                if (i != sel || cur_mode) check("rom_rd_unexpected", 1, 0);
                last_rd_cyc <= cyc;
                rd_seen     <= rd_seen + 1;
            end
            if (dut_done[i]) begin
                if (i != sel) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    done_seen <= done_seen + 1;
                    done_cyc  <= cyc;
                end
            end
        end
    end

    task automatic push_load(input bit m, input int n, input logic [15:0] eff_seed);
        exp_t e;
        logic [15:0] lf;
        lf = eff_seed;
        for (int i = 0; i < n; i++) begin
            e.addr = i;
            if (m) begin
                e.data = int'(lf[1:0]);
                lf = lfsr_next(lf);
            end else begin
                e.data = int'(rom_mem[i]);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic start_load(input int s, input bit m, input int c, input logic [15:0] sd);
        @(posedge clk); #1;
        mode_s  = m;
        count_s = (AW+1)'(c);
        seed_s  = sd;
        go_s[s] = 1'b1;
        @(posedge clk); #1;
        go_s[s] = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit got);
        got = 1'b0;
        for (int c = 0; c < bound && !got; c++) begin
            @(negedge clk); #1;
            if (dut_done[sel]) got = 1'b1;
        end
        if (!got) check("done_timeout", 0, 1);
    endtask

    task automatic wait_writes(input int target, input int bound, output bit got);
        got = 1'b0;
        for (int c = 0; c < bound && !got; c++) begin
            @(negedge clk); #1;
            if (wr_seen >= target) got = 1'b1;
        end
        if (!got) check("write_timeout", 0, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int base_wr, base_done, snap_rd;
        bit got;
        sel      = v.sel;
        cur_mode = v.mode;
        period   = v.mode ? 2 : ((v.sel == 0) ? 3 : 5);
        load_id++;
        push_load(v.mode, v.exp_writes, v.eff_seed);
        base_wr   = wr_seen;
        base_done = done_seen;
        start_load(v.sel, v.mode, v.count, v.seed);
        check("busy_after_go", int'(dut_busy[v.sel]), 1);
        if (v.abort_after > 0) begin
            wait_writes(base_wr + v.abort_after, 100, got);
            @(posedge clk); #1;
            abort_s = 1'b1;
            @(posedge clk); #1;
            abort_s = 1'b0;
            check("busy_after_abort", int'(dut_busy[v.sel]), 0);
            snap_rd = rd_seen;
            repeat (12) @(posedge clk);
            #1;
            check("rd_after_abort", rd_seen - snap_rd, 0);
            check("done_after_abort", done_seen - base_done, 0);
        end else begin
            wait_done(200, got);
            if (got) begin
                check("done_latency", done_cyc - last_wr_cyc, 1);
                @(posedge clk); #1;
                check("done_width", int'(dut_done[v.sel]), 0);
                check("busy_after_done", int'(dut_busy[v.sel]), 0);
            end
        end
        check("writes", wr_seen - base_wr, v.exp_writes);
        check("loaded", int'(dut_loaded[v.sel]), v.exp_loaded);
        check("queue_empty", exp_q.size(), 0);
        $display("load sel=%0d mode=%0d count=%0d writes=%0d loaded=%0d",
                 v.sel, v.mode, v.count, wr_seen - base_wr, dut_loaded[v.sel]);
        exp_q.delete();
    endtask

    vec_t vecs [10];

    initial begin
        int  base_wr;
        bit  got;

        go_s[0] = 1'b0;
        go_s[1] = 1'b0;
        mode_s  = 1'b0;
        count_s = '0;
        seed_s  = '0;
        abort_s = 1'b0;
        rom_mem[0] = 2'd0; rom_mem[1] = 2'd1; rom_mem[2] = 2'd2; rom_mem[3] = 2'd3;
        rom_mem[4] = 2'd3; rom_mem[5] = 2'd2; rom_mem[6] = 2'd1; rom_mem[7] = 2'd0;

        //           sel mode cnt seed      eff_seed  abort wr ld
        vecs[0] = '{0, 1'b0, 8, 16'h0000, 16'h0001, 0,    8, 8};
        vecs[1] = '{0, 1'b0, 3, 16'h0000, 16'h0001, 0,    3, 3};
        vecs[2] = '{0, 1'b0, 0, 16'h0000, 16'h0001, 0,    8, 8};
        vecs[3] = '{0, 1'b0, 9, 16'h0000, 16'h0001, 0,    8, 8};
        vecs[4] = '{0, 1'b1, 8, 16'h0001, 16'h0001, 0,    8, 8};
        vecs[5] = '{0, 1'b1, 8, 16'h0000, 16'h0001, 0,    8, 8};
        vecs[6] = '{1, 1'b0, 8, 16'h0000, 16'h0001, 2,    2, 2};
        vecs[7] = '{1, 1'b0, 4, 16'h0000, 16'h0001, 0,    4, 4};
        vecs[8] = '{1, 1'b1, 5, 16'hABCD, 16'hABCD, 0,    5, 5};
        vecs[9] = '{0, 1'b1, 1, 16'hBEEF, 16'hBEEF, 0,    1, 1};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(dut_busy[0]), 0);
        check("reset_loaded", int'(dut_loaded[0]), 0);
        check("reset_write", int'(dut_write[1]), 0);
        reset = 1'b1;

        // Asynchronous reset in the middle of a ROM load.
        sel = 0; cur_mode = 1'b0; period = 3; load_id++;
        push_load(1'b0, 8, 16'h0001);
        base_wr = wr_seen;
        start_load(0, 1'b0, 8, 16'h0000);
        wait_writes(base_wr + 2, 100, got);
        check("pre_reset_loaded", int'(dut_loaded[0] != 0), 1);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("async_rom_addr", int'(dut_rom_addr[0]), 0);
        check("async_rom_rd", int'(dut_rom_rd[0]), 0);
        check("async_wr_addr", int'(dut_wr_addr[0]), 0);
        check("async_wr_data", int'(dut_wr_data[0]), 0);
        check("async_write", int'(dut_write[0]), 0);
        check("async_done", int'(dut_done[0]), 0);
        check("async_loaded", int'(dut_loaded[0]), 0);
        check("async_busy", int'(dut_busy[0]), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // go while busy is ignored; go held from DONE into IDLE starts exactly one new load.
        sel = 0; cur_mode = 1'b0; period = 3; load_id++;
        push_load(1'b0, 8, 16'h0001);
        base_wr = wr_seen;
        start_load(0, 1'b0, 8, 16'h0000);
        repeat (6) @(posedge clk);
        #1;
        count_s = 4'd3;
        go_s[0] = 1'b1;
        @(posedge clk); #1;
        go_s[0] = 1'b0;
        wait_done(200, got);
        check("busy_go_writes", wr_seen - base_wr, 8);
        check("busy_go_loaded", int'(dut_loaded[0]), 8);
        check("busy_go_queue", exp_q.size(), 0);
        $display("load sel=0 mode=0 count=8 go-while-busy writes=%0d", wr_seen - base_wr);

        cur_mode = 1'b1; period = 2; load_id++;
        push_load(1'b1, 3, 16'h0005);
        base_wr = wr_seen;
        mode_s  = 1'b1;
        count_s = 4'd3;
        seed_s  = 16'h0005;
        go_s[0] = 1'b1;
        @(posedge clk); #1;
        check("go_in_done_ignored", int'(dut_busy[0]), 0);
        @(posedge clk); #1;
        go_s[0] = 1'b0;
        check("restart_busy", int'(dut_busy[0]), 1);
        check("restart_loaded_zero", int'(dut_loaded[0]), 0);
        wait_done(100, got);
        @(posedge clk); #1;
        check("restart_writes", wr_seen - base_wr, 3);
        check("restart_loaded", int'(dut_loaded[0]), 3);
        check("restart_queue", exp_q.size(), 0);
        $display("load sel=0 mode=1 count=3 after-done writes=%0d", wr_seen - base_wr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
